// File: rtl/deser_rx_if.sv
// Parallel output channel of the serial receiver: word plus valid/ready handshake.
interface deser_rx_if #(
    parameter int N = 4
);
    logic [N-1:0] dout;
    logic         dout_valid;
    logic         dout_ready;

    modport master (
        output dout,
        output dout_valid,
        input  dout_ready
    );

    modport slave (
        input  dout,
        input  dout_valid,
        output dout_ready
    );
endinterface

// File: rtl/deser_rx.sv
// Framed serial receiver: start bit 1, N data bits, stop bit 0; the word is
// presented in a valid/ready holding register with sticky overrun/frame flags.
module deser_rx #(
    parameter int N         = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         res,
    input  logic         en,
    input  logic         din,
    input  logic         clr,
    deser_rx_if.master   rx,
    output logic         busy,
    output logic         overrun,
    output logic         frame_err
);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  shreg_q, shreg_d;
    logic [N-1:0]  dout_q, dout_d;
    logic          vld_q, vld_d;
    logic          ovr_q, ovr_d;
    logic          ferr_q, ferr_d;
    logic          good_stop, bad_stop, handshake;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        good_stop = 1'b0;
        bad_stop  = 1'b0;
        if (en) begin
            unique case (state_q)
                IDLE: begin
                    if (din) begin
                        state_d = DATA;
                        cnt_d   = '0;
                    end
                end
                DATA: begin
                    shreg_d = MSB_FIRST ? {shreg_q[N-2:0], din} : {din, shreg_q[N-1:1]};
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == CW'(N - 1)) begin
                        state_d = STOP;
                    end
                end
                STOP: begin
                    // A high stop bit is an error only; it never restarts a frame.
                    good_stop = ~din;
                    bad_stop  = din;
                    state_d   = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Holding register: a drain on the delivery edge makes room for the new word.
    always_comb begin
        handshake = vld_q & rx.dout_ready;
        dout_d    = dout_q;
        vld_d     = vld_q;
        ovr_d     = ovr_q & ~clr;
        ferr_d    = (ferr_q & ~clr) | bad_stop;
        if (good_stop) begin
            if (!vld_q || handshake) begin
                dout_d = shreg_q;
                vld_d  = 1'b1;
            end else begin
                ovr_d  = 1'b1;
            end
        end else if (handshake) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dout_q  <= '0;
            vld_q   <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            vld_q   <= vld_d;
            ovr_q   <= ovr_d;
            ferr_q  <= ferr_d;
        end
    end

    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
    end

    assign rx.dout       = dout_q;
    assign rx.dout_valid = vld_q;
    assign busy          = (state_q != IDLE);
    assign overrun       = ovr_q;
    assign frame_err     = ferr_q;
endmodule

// File: tb/tb_deser_rx.sv
// Bench for deser_rx: an MSB-first and an LSB-first instance share one serial line.
module tb_deser_rx;
    logic clk = 1'b0;
    logic res, en, din, clr, ready;
    logic busy_m, ovr_m, ferr_m, busy_l, ovr_l, ferr_l;
    int   errors = 0;
    int   checks = 0;
    logic [3:0] exp_m[$];
    logic [3:0] exp_l[$];

    always #5 clk = ~clk;

    deser_rx_if #(.N(4)) if_m ();
    deser_rx_if #(.N(4)) if_l ();
    assign if_m.dout_ready = ready;
    assign if_l.dout_ready = ready;

    deser_rx #(.N(4), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .res(res), .en(en), .din(din), .clr(clr), .rx(if_m),
        .busy(busy_m), .overrun(ovr_m), .frame_err(ferr_m)
    );
    deser_rx #(.N(4), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .res(res), .en(en), .din(din), .clr(clr), .rx(if_l),
        .busy(busy_l), .overrun(ovr_l), .frame_err(ferr_l)
    );

    function automatic logic [3:0] rev4(input logic [3:0] w);
        return {w[0], w[1], w[2], w[3]};
    endfunction

    // Scoreboard: every handshake pops the next expected word of each instance.
    always @(negedge clk) begin
        if (res === 1'b0 && ready === 1'b1) begin
            if (if_m.dout_valid === 1'b1) begin
                checks++;
                if (exp_m.size() == 0) begin
                    errors++;
                    $display("FAIL sb_msb_unexpected: got %b, required no word", if_m.dout);
                end else begin
                    logic [3:0] e;
                    e = exp_m.pop_front();
                    if (if_m.dout !== e) begin
                        errors++;
                        $display("FAIL sb_msb_word: got %b, required %b", if_m.dout, e);
                    end
                end
            end
            if (if_l.dout_valid === 1'b1) begin
                checks++;
                if (exp_l.size() == 0) begin
                    errors++;
                    $display("FAIL sb_lsb_unexpected: got %b, required no word", if_l.dout);
                end else begin
                    logic [3:0] e;
                    e = exp_l.pop_front();
                    if (if_l.dout !== e) begin
                        errors++;
                        $display("FAIL sb_lsb_word: got %b, required %b", if_l.dout, e);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [3:0] w);
        din = 1'b1;
        tick();
        for (int i = 3; i >= 0; i--) begin
            din = w[i];
            tick();
        end
        din = 1'b0;
        tick();
    endtask

    task automatic expect_word(input logic [3:0] w);
        exp_m.push_back(w);
        exp_l.push_back(rev4(w));
    endtask

    task automatic test_reset();
        res = 1'b1; en = 1'b1; din = 1'b0; clr = 1'b0; ready = 1'b0;
        tick();
        checks++;
        if ({if_m.dout, if_m.dout_valid, busy_m, ovr_m, ferr_m,
             if_l.dout, if_l.dout_valid, busy_l, ovr_l, ferr_l} !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %b/%b/%b/%b/%b, required all zero",
                     if_m.dout, if_m.dout_valid, busy_m, ovr_m, ferr_m);
        end
        res = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [5:0] seq;
        int busy_cnt;
        seq = 6'b110110;
        busy_cnt = 0;
        ready = 1'b1;
        expect_word(4'b1011);
        for (int i = 5; i >= 0; i--) begin
            din = seq[i];
            tick();
            if (busy_m === 1'b1) busy_cnt++;
        end
        checks++;
        if ({if_m.dout_valid, if_m.dout, if_l.dout_valid, if_l.dout} !== {1'b1, 4'b1011, 1'b1, 4'b1101}) begin
            errors++;
            $display("FAIL basic_word: got msb %b/%b lsb %b/%b, required 1/1011 1/1101",
                     if_m.dout_valid, if_m.dout, if_l.dout_valid, if_l.dout);
        end
        din = 1'b0;
        tick();
        if (busy_m === 1'b1) busy_cnt++;
        checks++;
        if (if_m.dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_valid_one_cycle: got valid %b, required 0", if_m.dout_valid);
        end
        checks++;
        if (busy_cnt != 5) begin
            errors++;
            $display("FAIL basic_busy_cycles: got %0d, required 5", busy_cnt);
        end
        checks++;
        if ({ovr_m, ferr_m, ovr_l, ferr_l} !== 4'b0000) begin
            errors++;
            $display("FAIL basic_flags: got %b%b, required 00", ovr_m, ferr_m);
        end
    endtask

    task automatic test_back_to_back();
        ready = 1'b0;
        send_frame(4'b1010);
        checks++;
        if ({if_m.dout_valid, if_m.dout} !== {1'b1, 4'b1010}) begin
            errors++;
            $display("FAIL b2b_first: got %b/%b, required 1/1010", if_m.dout_valid, if_m.dout);
        end
        send_frame(4'b0110);
        checks++;
        if ({if_m.dout, if_l.dout, ovr_m, ovr_l} !== {4'b1010, 4'b0101, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL b2b_overrun: got dout %b ovr %b, required 1010 1", if_m.dout, ovr_m);
        end
        expect_word(4'b1010);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        checks++;
        if (if_m.dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: got valid %b, required 0", if_m.dout_valid);
        end
        send_frame(4'b0011);
        checks++;
        if ({if_m.dout_valid, if_m.dout, if_l.dout} !== {1'b1, 4'b0011, 4'b1100}) begin
            errors++;
            $display("FAIL b2b_third: got %b/%b, required 1/0011", if_m.dout_valid, if_m.dout);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++;
        if ({ovr_m, ferr_m, ovr_l, ferr_l, if_m.dout_valid} !== 5'b00001) begin
            errors++;
            $display("FAIL b2b_clear: got ovr %b ferr %b valid %b, required 0 0 1",
                     ovr_m, ferr_m, if_m.dout_valid);
        end
        expect_word(4'b0011);
        ready = 1'b1;
        tick();
    endtask

    task automatic test_stop_err();
        logic [5:0] seq;
        seq = 6'b101111;
        ready = 1'b1;
        for (int i = 5; i >= 0; i--) begin
            din = seq[i];
            tick();
        end
        checks++;
        if ({ferr_m, ferr_l, if_m.dout_valid, busy_m} !== 4'b1100) begin
            errors++;
            $display("FAIL stop_err: got ferr %b valid %b busy %b, required 1 0 0",
                     ferr_m, if_m.dout_valid, busy_m);
        end
        din = 1'b0;
        tick();
        checks++;
        if (busy_m !== 1'b0) begin
            errors++;
            $display("FAIL stop_err_idle: got busy %b, required 0", busy_m);
        end
        expect_word(4'b0110);
        send_frame(4'b0110);
        checks++;
        if ({if_m.dout_valid, if_m.dout, ferr_m} !== {1'b1, 4'b0110, 1'b1}) begin
            errors++;
            $display("FAIL stop_err_recover: got %b/%b ferr %b, required 1/0110 1",
                     if_m.dout_valid, if_m.dout, ferr_m);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++;
        if ({ferr_m, ferr_l} !== 2'b00) begin
            errors++;
            $display("FAIL stop_err_clr: got %b, required 0", ferr_m);
        end
    endtask

    task automatic test_en_gating();
        ready = 1'b1;
        expect_word(4'b1100);
        din = 1'b1; tick();
        din = 1'b1; tick();
        din = 1'b1; tick();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            din = i[0];
            tick();
        end
        checks++;
        if (busy_m !== 1'b1) begin
            errors++;
            $display("FAIL en_busy_hold: got %b, required 1", busy_m);
        end
        en = 1'b1;
        din = 1'b0; tick();
        din = 1'b0; tick();
        checks++;
        if (if_m.dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL en_early_valid: got %b, required 0", if_m.dout_valid);
        end
        din = 1'b0; tick();
        checks++;
        if ({if_m.dout_valid, if_m.dout, if_l.dout} !== {1'b1, 4'b1100, 4'b0011}) begin
            errors++;
            $display("FAIL en_word: got %b/%b lsb %b, required 1/1100 0011",
                     if_m.dout_valid, if_m.dout, if_l.dout);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        ready = 1'b1;
        din = 1'b1; tick();
        din = 1'b0; tick();
        din = 1'b1; tick();
        res = 1'b1; din = 1'b1;
        tick();
        checks++;
        if ({if_m.dout, if_m.dout_valid, busy_m, ovr_m, ferr_m,
             if_l.dout, if_l.dout_valid, busy_l, ovr_l, ferr_l} !== 16'h0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got %b/%b/%b, required 0/0/0",
                     if_m.dout, if_m.dout_valid, busy_m);
        end
        res = 1'b0; din = 1'b0;
        tick();
        expect_word(4'b0101);
        send_frame(4'b0101);
        checks++;
        if ({if_m.dout_valid, if_m.dout, if_l.dout} !== {1'b1, 4'b0101, 4'b1010}) begin
            errors++;
            $display("FAIL reset_mid_fresh: got %b/%b lsb %b, required 1/0101 1010",
                     if_m.dout_valid, if_m.dout, if_l.dout);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_stop_err();
        test_en_gating();
        test_reset_mid();
        tick();
        checks++;
        if (exp_m.size() != 0 || exp_l.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d/%0d words undelivered, required 0",
                     exp_m.size(), exp_l.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/deser_rx.md
# deser_rx

Serial-to-parallel framed receiver that recovers N-bit words from a single-bit serial line, the receive-side counterpart of the team's parallel-load serial shift register. It hunts for a start bit, shifts in N data bits, checks a stop bit and presents the word on a valid/ready output holding register. Error conditions are reported through sticky flags. It sits at the far end of a serial link or loopback path and feeds a parallel consumer.

## Interface
- `N`, default 4: data bits per frame, ≥ 2.
- `MSB_FIRST`, default 1: 1 means the first data bit received lands in `dout[N-1]`; 0 means it lands in `dout[0]`.

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `res`  in  1: one clock; reset is synchronous and active-high.
- `en`  in  1: sample enable; when low, the receive FSM, shift register and bit counter hold.
- `din`  in  1: serial line, idle level 0.
- `clr`  in  1: clears the sticky `overrun` and `frame_err` flags.
- `dout`  out  N: received word; stable while `dout_valid`=1.
- `dout_valid`  out  1: holding register contains an unconsumed word.
- `dout_ready`  in  1: consumer accepts the word when it is high and `dout_valid` is high.
- `busy`  out  1: a frame is in progress (state ≠ IDLE).
- `overrun`  out  1: sticky; a good frame was dropped because the holding register was full.
- `frame_err`  out  1: sticky; a stop bit was sampled as 1.

## Operation
- Frame format on `din`, one bit per enabled cycle:
  - start bit = 1;
  - N data bits;
  - stop bit = 0.
- FSM states, evaluated only on edges with `en`=1:
  - IDLE:
    - `din`=1: go to DATA, bit counter ← 0.
    - Otherwise: stay in IDLE.
  - DATA:
    - Shift `din` into the shift register per `MSB_FIRST`; counter increments.
    - When counter = N-1 (Nth bit taken): go to STOP.
  - STOP:
    - `din`=0 (good frame): attempt delivery to the holding register.
    - `din`=1: set `frame_err`, discard the word.
    - Always go to IDLE.
    - A stop bit of 1 is not reinterpreted as a new start bit.
- Delivery on a good frame:
  - Holding register empty, or drained in the same cycle (`dout_valid` & `dout_ready`): load the word, `dout_valid` = 1.
  - Otherwise: set `overrun`. The old word is kept; the new word is dropped.
- Consumption:
  - A handshake with no delivery in the same cycle clears `dout_valid`.
  - The output handshake runs regardless of `en`.
- Sticky flags:
  - Cleared by `clr`.
  - If `clr` and a new error occur on the same edge, the flag ends up set (set wins).
- Counter width is `$clog2(N)`. The shift register is N bits and holds stale bits between frames; only delivery updates `dout`.

## Timing
- Reset values (on the edge with `res`=1):
  - state = IDLE;
  - `dout` = 0, `dout_valid` = 0, `busy` = 0, `overrun` = 0, `frame_err` = 0;
  - counter = 0.
- `res` overrides everything: reset mid-frame abandons the frame, and no partial word is delivered.
- Frame length is N+2 enabled cycles.
  - Start bit sampled on edge s; the data bits on edges s+1..s+N; the stop bit on edge s+N+1.
  - `dout_valid` rises after edge s+N+1, so latency from the start-bit edge is N+1 cycles.
- `busy` is high from after edge s through edge s+N+1, then low.
- Back-to-back frames: the next start bit may be sampled on edge s+N+2, giving zero idle cycles.
- `en` low for k cycles stretches the frame by exactly k cycles; the data is unaffected.
- `dout` changes only on a delivery edge. `dout_valid` is never deasserted without a handshake or `res`.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Basic frame, N=4, `MSB_FIRST`=1, `dout_ready`=1:
  - `din` sequence 1, 1,0,1,1, 0.
  - Required: `dout`=4'b1011, `dout_valid` for 1 cycle, `busy` high for 5 cycles, no flags set.
- Bit order, `MSB_FIRST`=0, same `din` sequence → `dout`=4'b1101.
- Back-to-back frames with `dout_ready`=0:
  - Frame A=4'b1010, then immediately frame B=4'b0110.
  - Required: `dout` stays 4'b1010 and `overrun` is set.
  - Then pulse `dout_ready` for 1 cycle, a third frame 4'b0011 arrives, then `clr`: `dout_valid` drops, `dout`=4'b0011 arrives, and the flags return to 0.
- Stop bit error:
  - Frame 1, 0,1,1,1, 1 → `frame_err`=1, `dout_valid` stays 0.
  - The following 0 cycle keeps the FSM in IDLE (`busy`=0); the next good frame is received normally.
- `en` gating: hold `en`=0 for 3 cycles mid-DATA while `din` toggles → the word matches the bits sampled with `en`=1 only, and `dout_valid` is delayed by exactly 3 cycles.
- Reset mid-frame:
  - Assert `res` after 2 data bits → all outputs 0 on the next edge.
  - A fresh frame 4'b0101 is then received correctly.
